// File: rtl/rbm_psum_tx_pkg.sv
// Shared definitions for the RBM partial-sum transmitter: FSM state encoding
// and the default sizing constants that mirror the system-level defines.
package rbm_psum_tx_pkg;

    localparam int unsigned DefNumCoreH = 16;
    localparam int unsigned DefBwPs     = 16;
    localparam int unsigned DefNumNode  = 64;
    localparam int unsigned DefTimeout  = 15;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StSend,
        StWait,
        StDone
    } state_e;

endpackage

// File: rtl/rbm_psum_tx_psum_buffer.sv
// Partial-sum register file: one write port, one registered read port.
// A read of the address being written in the same cycle returns the new data.
module psum_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read with write-first forwarding on an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
        end
    end

endmodule

// File: rtl/rbm_psum_tx.sv
// RBM partial-sum transmitter: buffers NUM_CORE_H partial sums per node from
// the PE array, streams them to the sampling core, then collects the sampled
// binary state for that node, over NUM_NODE nodes per layer pass.
module rbm_psum_tx
    import rbm_psum_tx_pkg::*;
#(
    parameter int unsigned NUM_CORE_H = DefNumCoreH,
    parameter int unsigned BW_PS      = DefBwPs,
    parameter int unsigned NUM_NODE   = DefNumNode,
    parameter int unsigned TIMEOUT    = DefTimeout
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    start,
    input  logic                    psum_wr_en,
    input  logic signed [BW_PS-1:0] psum_wr_data,
    output logic                    psum_ready,
    output logic                    busy,
    output logic                    data_out_en,
    output logic signed [BW_PS-1:0] data_out,
    input  logic                    new_state,
    input  logic                    new_state_en,
    output logic [NUM_NODE-1:0]     state_vec,
    output logic                    layer_done,
    output logic                    err_timeout
);

    localparam int unsigned PW = $clog2(NUM_CORE_H + 1);
    localparam int unsigned NW = (NUM_NODE > 1) ? $clog2(NUM_NODE) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned AW = (NUM_CORE_H > 1) ? $clog2(NUM_CORE_H) : 1;

    localparam logic [PW-1:0] PtrLast  = PW'(NUM_CORE_H - 1);
    localparam logic [PW-1:0] PtrEnd   = PW'(NUM_CORE_H);
    localparam logic [NW-1:0] NodeLast = NW'(NUM_NODE - 1);
    localparam logic [TW-1:0] TmoLast  = TW'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]       node_idx_q, node_idx_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [NUM_NODE-1:0] state_vec_q, state_vec_d;
    logic                err_q, err_d;
    logic                dout_en_q, dout_en_d;

    logic                buf_wr;
    logic                buf_rd;
    logic [AW-1:0]       buf_raddr;
    logic [BW_PS-1:0]    buf_rdata;

    psum_buffer #(
        .DEPTH (NUM_CORE_H),
        .WIDTH (BW_PS),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (buf_wr),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (psum_wr_data),
        .rd_en   (buf_rd),
        .rd_addr (buf_raddr),
        .rd_data (buf_rdata)
    );

    // Next-state and datapath control; nothing advances while en is low.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        node_idx_d  = node_idx_q;
        tmo_d       = tmo_q;
        state_vec_d = state_vec_q;
        err_d       = err_q;
        dout_en_d   = 1'b0;
        buf_wr      = 1'b0;
        buf_rd      = 1'b0;
        buf_raddr   = rd_ptr_q[AW-1:0];
        psum_ready  = (state_q == StFill) && (wr_ptr_q < PtrEnd);

        if (en) begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d     = StFill;
                        node_idx_d  = '0;
                        wr_ptr_d    = '0;
                        state_vec_d = '0;
                    end
                end
                StFill: begin
                    if (psum_wr_en && psum_ready) begin
                        buf_wr   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        if (wr_ptr_q == PtrLast) begin
                            // Fetch beat 0 on the last write so it is valid in the
                            // first SEND cycle; rd_ptr then counts beats issued.
                            state_d   = StSend;
                            buf_rd    = 1'b1;
                            buf_raddr = '0;
                            dout_en_d = 1'b1;
                            rd_ptr_d  = PW'(1);
                        end
                    end
                end
                StSend: begin
                    if (rd_ptr_q == PtrEnd) begin
                        state_d = StWait;
                        tmo_d   = '0;
                    end else begin
                        buf_rd    = 1'b1;
                        dout_en_d = 1'b1;
                        rd_ptr_d  = rd_ptr_q + PW'(1);
                    end
                end
                StWait: begin
                    if (new_state_en || (tmo_q == TmoLast)) begin
                        // A missed response records the node as 0 and flags it.
                        state_vec_d[node_idx_q] = new_state_en ? new_state : 1'b0;
                        if (!new_state_en) begin
                            err_d = 1'b1;
                        end
                        if (node_idx_q == NodeLast) begin
                            state_d = StDone;
                        end else begin
                            node_idx_d = node_idx_q + NW'(1);
                            wr_ptr_d   = '0;
                            state_d    = StFill;
                        end
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State registers; reset wins over en, en low freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            node_idx_q  <= '0;
            tmo_q       <= '0;
            state_vec_q <= '0;
            err_q       <= 1'b0;
            dout_en_q   <= 1'b0;
        end else if (en) begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            node_idx_q  <= node_idx_d;
            tmo_q       <= tmo_d;
            state_vec_q <= state_vec_d;
            err_q       <= err_d;
            dout_en_q   <= dout_en_d;
        end
    end

    // A held beat is not presented while disabled, so it is delivered once.
    assign data_out_en = dout_en_q && en;
    assign data_out    = buf_rdata;
    assign busy        = (state_q != StIdle);
    assign layer_done  = (state_q == StDone) && en;
    assign state_vec   = state_vec_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_rbm_psum_tx.sv
// Self-checking bench for rbm_psum_tx: a cycle table for the nominal pass,
// directed multi-cycle sequences, and randomized passes against a pass-level model.
module tb_rbm_psum_tx;

    localparam int unsigned NC = 4;
    localparam int unsigned BW = 16;
    localparam int unsigned NN = 2;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst, en, start, psum_wr_en, new_state, new_state_en;
    logic [BW-1:0] psum_wr_data, data_out;
    logic          psum_ready, busy, data_out_en, layer_done, err_timeout;
    logic [NN-1:0] state_vec;

    rbm_psum_tx #(
        .NUM_CORE_H (NC),
        .BW_PS      (BW),
        .NUM_NODE   (NN),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .start        (start),
        .psum_wr_en   (psum_wr_en),
        .psum_wr_data (psum_wr_data),
        .psum_ready   (psum_ready),
        .busy         (busy),
        .data_out_en  (data_out_en),
        .data_out     (data_out),
        .new_state    (new_state),
        .new_state_en (new_state_en),
        .state_vec    (state_vec),
        .layer_done   (layer_done),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          start, we;
        logic [BW-1:0] wd;
        logic          nse, ns;
        logic [3:0]    exp;   // {busy, psum_ready, data_out_en, layer_done}
        logic [BW-1:0] edout; // checked only when data_out_en is expected
    } vec_t;

    vec_t          tbl[$];
    int            vectors = 0;
    int            errors = 0;
    int            ld_count = 0;
    logic [BW-1:0] beats[$];
    logic [BW-1:0] exp_q[$];
    logic          err_model;
    logic [BW-1:0] pdata [NN][NC];
    int            pdly [NN];
    logic          pbit [NN];
    logic          pextra;
    int            pgap;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic we, input logic [BW-1:0] wd, input logic nse,
                       input logic ns, input logic [3:0] exp, input logic [BW-1:0] edout);
        vec_t v;
        v.start = s; v.we = we; v.wd = wd; v.nse = nse; v.ns = ns; v.exp = exp; v.edout = edout;
        tbl.push_back(v);
    endtask

    // One clock: sample outputs mid-cycle, then step to just after the next edge.
    task automatic tick();
        @(negedge clk);
        if (data_out_en === 1'b1) beats.push_back(data_out);
        if (layer_done === 1'b1) ld_count++;
        if (en === 1'b0) check("doe_while_disabled", {63'd0, data_out_en}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int n = 0; n < NN; n++)
            for (int i = 0; i < NC; i++) pdata[n][i] = BW'($urandom);
    endtask

    task automatic fill_node(input int n);
        for (int i = 0; i < NC; i++) begin
            while (pgap == 1 && $urandom_range(0, 2) == 0) begin
                en = 1'($urandom_range(0, 1));
                tick();
            end
            en = 1'b1;
            psum_wr_en = 1'b1;
            psum_wr_data = pdata[n][i];
            exp_q.push_back(pdata[n][i]);
            tick();
            psum_wr_en = 1'b0;
        end
        if (pextra) begin
            psum_wr_en = 1'b1;
            psum_wr_data = 16'h7777;
            tick();
            psum_wr_en = 1'b0;
        end
    endtask

    // Returns in the first cycle after the target beat count has been seen.
    task automatic wait_beats(input int target);
        int budget = 300;
        int gap_left = 3;
        while (beats.size() < target && budget > 0) begin
            if (pgap == 1) en = ($urandom_range(0, 3) != 0);
            else if (pgap == 2 && beats.size() == target - 2 && gap_left > 0) begin
                en = 1'b0;
                gap_left--;
            end else en = 1'b1;
            tick();
            budget--;
        end
        en = 1'b1;
        if (beats.size() < target) check("beat_budget", 64'(beats.size()), 64'(target));
    endtask

    task automatic respond(input int n, output logic bitv);
        if (pdly[n] < int'(TO)) begin
            repeat (pdly[n]) tick();
            new_state_en = 1'b1;
            new_state = pbit[n];
            tick();
            new_state_en = 1'b0;
            new_state = 1'b0;
            bitv = pbit[n];
        end else begin
            for (int i = 0; i < int'(TO); i++) begin
                check("err_pending", {63'd0, err_timeout}, {63'd0, err_model});
                tick();
            end
            err_model = 1'b1;
            check("err_set", {63'd0, err_timeout}, 64'd1);
            bitv = 1'b0;
        end
    endtask

    task automatic run_pass();
        logic [NN-1:0] exp_sv;
        int ld0;
        logic b;
        exp_sv = '0;
        ld0 = ld_count;
        exp_q.delete();
        beats.delete();
        en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < NN; n++) begin
            fill_node(n);
            wait_beats((n + 1) * NC);
            respond(n, b);
            exp_sv[n] = b;
        end
        repeat (3) tick();
        check("beat_count", 64'(beats.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < beats.size(); i++)
            check($sformatf("beat%0d", i), 64'(beats[i]), 64'(exp_q[i]));
        check("state_vec", 64'(state_vec), 64'(exp_sv));
        check("err_timeout", {63'd0, err_timeout}, {63'd0, err_model});
        check("layer_done_pulses", 64'(ld_count - ld0), 64'd1);
        check("busy_after_pass", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic b;
        rst = 1'b1; en = 1'b0; start = 1'b0; psum_wr_en = 1'b0; psum_wr_data = '0;
        new_state = 1'b0; new_state_en = 1'b0; err_model = 1'b0; pgap = 0; pextra = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        en = 1'b1;
        #1;
        check("rst_outputs", {59'd0, busy, psum_ready, data_out_en, layer_done, err_timeout},
              64'd0);
        check("rst_state_vec", 64'(state_vec), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);

        // Nominal pass, cycle by cycle.
        add(1, 0, 0, 0, 0, 4'b0000, 0);
        add(0, 1, 5, 0, 0, 4'b1100, 0);
        add(0, 1, 16'hfffd, 0, 0, 4'b1100, 0);
        add(0, 1, 7, 0, 0, 4'b1100, 0);
        add(0, 1, 1, 0, 0, 4'b1100, 0);
        add(0, 0, 0, 0, 0, 4'b1010, 5);
        add(0, 0, 0, 0, 0, 4'b1010, 16'hfffd);
        add(0, 0, 0, 0, 0, 4'b1010, 7);
        add(0, 0, 0, 0, 0, 4'b1010, 1);
        add(0, 0, 0, 0, 0, 4'b1000, 0);
        add(0, 0, 0, 0, 0, 4'b1000, 0);
        add(0, 0, 0, 1, 1, 4'b1000, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 2, 0, 0, 4'b1100, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 4'b1010, 2);
        add(0, 0, 0, 0, 0, 4'b1000, 0);
        add(0, 0, 0, 0, 0, 4'b1000, 0);
        add(0, 0, 0, 1, 0, 4'b1000, 0);
        add(0, 0, 0, 0, 0, 4'b1001, 0);
        add(0, 0, 0, 0, 0, 4'b0000, 0);
        foreach (tbl[i]) begin
            start = tbl[i].start; psum_wr_en = tbl[i].we; psum_wr_data = tbl[i].wd;
            new_state_en = tbl[i].nse; new_state = tbl[i].ns;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  64'({busy, psum_ready, data_out_en, layer_done,
                       (tbl[i].exp[1] ? data_out : 16'h0)}),
                  64'({tbl[i].exp, tbl[i].edout}));
            @(posedge clk);
            #1;
        end
        start = 1'b0; psum_wr_en = 1'b0; new_state_en = 1'b0; new_state = 1'b0;
        check("nominal_state_vec", 64'(state_vec), 64'd1);
        check("nominal_err", {63'd0, err_timeout}, 64'd0);

        // Backpressure: extra write right after the fourth is dropped.
        rand_data(); pextra = 1'b1; pgap = 0;
        pdly[0] = 2; pbit[0] = 1'b1; pdly[1] = 1; pbit[1] = 1'b1;
        run_pass();

        // Timeout on node 0, node 1 answers normally.
        rand_data(); pextra = 1'b0;
        pdly[0] = TO; pbit[0] = 1'b1; pdly[1] = 0; pbit[1] = 1'b1;
        run_pass();

        // Three-cycle enable gap in the middle of SEND.
        rand_data(); pgap = 2;
        pdly[0] = 1; pbit[0] = 1'b0; pdly[1] = 4; pbit[1] = 1'b1;
        run_pass();

        // Reset while waiting on node 1 aborts the pass.
        rand_data(); pgap = 0; pdly[0] = 1; pbit[0] = 1'b1;
        exp_q.delete(); beats.delete();
        en = 1'b1; start = 1'b1; tick(); start = 1'b0;
        fill_node(0); wait_beats(NC); respond(0, b);
        fill_node(1); wait_beats(2 * NC);
        tick(); tick();
        check("sv_before_rst", 64'(state_vec), 64'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_state_vec", 64'(state_vec), 64'd0);
        check("rst_mid_err", {63'd0, err_timeout}, 64'd0);
        err_model = 1'b0;
        rand_data(); pdly[0] = 3; pbit[0] = 1'b0; pdly[1] = 0; pbit[1] = 1'b1;
        run_pass();

        // Randomized passes.
        for (int p = 0; p < 8; p++) begin
            rand_data();
            pgap = $urandom_range(0, 1);
            pextra = 1'($urandom_range(0, 1));
            for (int n = 0; n < NN; n++) begin
                pdly[n] = $urandom_range(0, 10);
                pbit[n] = 1'($urandom_range(0, 1));
            end
            run_pass();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
